i2c_slave_rx: RTL and testbench
===============================

// Module: i2c_slave_rx
// PURPOSE
//  Parametrised I2C write-only target receiver for the I2C-to-UART bridge. Oversamples SCL/SDA on
//  the system clock, detects START/STOP/repeated START, matches a 7-bit address and ACKs it.
//  Buffers received data bytes in a FIFO and offers them to the UART TX side over valid/ready.
// PARAMETERS
//  DEVICE_ADDR  7'h77  7-bit target address, compared MSB first against the first 7 bits after START
//  FIFO_DEPTH   4      receive byte FIFO entries; power of two, >=2
//  SYNC_STAGES  2      synchroniser flops on scl_i/sda_i, >=2
// PORTS
//  clk        in   1  system clock, >= 10x SCL rate
//  rst        in   1  synchronous, active-high reset
//  scl_i      in   1  SCL pad input (asynchronous)
//  sda_i      in   1  SDA pad input (asynchronous)
//  sda_oe     out  1  1 = drive SDA pad low (open-drain); 0 = release
//  rx_data    out  8  FIFO head byte
//  rx_valid   out  1  FIFO non-empty
//  rx_ready   in   1  consumer accepts head when rx_valid & rx_ready
//  busy       out  1  high from START until STOP
//  addr_hit   out  1  one-clk pulse when address+W is ACKed
//  overrun    out  1  one-clk pulse when a data byte is NACKed/dropped because FIFO is full
//  stop_det   out  1  one-clk pulse on STOP
// BEHAVIOUR
//  - Reset: sda_oe=0, rx_valid=0, rx_data=0, busy=0, all pulses 0, FIFO flushed, state IDLE.
//  - scl_s/sda_s = scl_i/sda_i after SYNC_STAGES flops; edges compare scl_s/sda_s to 1-clk-delayed copy.
//  - START: sda_s falls while scl_s high. STOP: sda_s rises while scl_s high. Both honoured in every state;
//    START (incl. repeated) -> ADDR, bit count 0, sda_oe=0; STOP -> IDLE, sda_oe=0, stop_det pulse.
//  - Data bits sampled on scl_s rising edge, MSB first; SDA changes while SCL low are not START/STOP.
//  - States: IDLE -> ADDR (8 bits: addr[6:0], R/W) -> ADDR_ACK -> DATA (8 bits) -> DATA_ACK -> DATA ...
//    ADDR mismatch or R/W=1 -> IGNORE (sda_oe held 0) until START/STOP.
//  - ACK: on scl_s falling edge after 8th bit, sda_oe=1 if ACKing; released on the next scl_s falling
//    edge (end of 9th clock). NACK = sda_oe stays 0 through the 9th clock.
//  - Address ACK when addr==DEVICE_ADDR and R/W=0; addr_hit pulses on the clk the ACK is asserted.
//  - Data byte: at the 8th-bit rising edge, if FIFO count<FIFO_DEPTH push byte and ACK; else drop, NACK,
//    overrun pulse. After a NACKed data byte remain in DATA (host may continue; each full byte NACKed).
//  - Full test uses registered count: push refused when full even if a pop occurs the same clk.
//  - Simultaneous push/pop when not full/empty: count unchanged, both take effect.
//  - rx_valid/rx_data update 1 clk after push into empty FIFO; pop exposes next entry next clk.
//  - Pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
//  - STOP/START mid-byte: partial byte discarded, no push. FIFO contents never flushed except by rst.
// CONFIGURATION
//  I2C_GENERAL_CALL_EN defined: address 7'h00 with R/W=0 is also ACKed (addr_hit pulses) and following
//   data bytes are pushed exactly as for DEVICE_ADDR. Undefined: 7'h00 goes to IGNORE (NACK).
// TESTING
//  - rst high 2 clk mid-byte -> sda_oe=0, rx_valid=0, busy=0; next START then 0xEE,0x41 -> ACKs, rx_data=0x41.
//  - START, 0xEE, 0x5A, 0xC3, STOP -> three ACKs; FIFO yields 0x5A then 0xC3; stop_det one pulse.
//  - START, 0xEF (read) -> NACK, sda_oe never 1, no FIFO push until STOP.
//  - rx_ready=0, write 5 bytes 0x01..0x05 with FIFO_DEPTH=4 -> 4 ACKs, 5th NACK, overrun once; drain 01..04.
//  - START, 0xEE, 4 bits, repeated START, 0xEE, 0x99 -> partial discarded, addr_hit twice, only 0x99 pushed.
//  - START, 0x00, 0x12: with I2C_GENERAL_CALL_EN -> ACK, 0x12 pushed; without -> NACK, FIFO empty.

Source files
------------

// File: rtl/i2c_slave_rx_if.sv
// i2c_slave_rx_if: I2C pad signals and receive-byte stream of i2c_slave_rx
interface i2c_slave_rx_if;
  logic scl_i, sda_i, sda_oe;
  logic [7:0] rx_data;
  logic rx_valid, rx_ready;
  logic busy, addr_hit, overrun, stop_det;
  modport master(output scl_i, sda_i, rx_ready,
                 input sda_oe, rx_data, rx_valid, busy, addr_hit, overrun, stop_det);
  modport slave(input scl_i, sda_i, rx_ready,
                output sda_oe, rx_data, rx_valid, busy, addr_hit, overrun, stop_det);
endinterface

// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: I2C write-only target receiver with byte FIFO; define I2C_GENERAL_CALL_EN to also ACK address 0x00
module i2c_slave_rx #(
  parameter logic [6:0] DEVICE_ADDR = 7'h77,
  parameter int FIFO_DEPTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  i2c_slave_rx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] scl_sr, sda_sr;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start, stop, last, addr_ok, push, pop;
  logic ph, ack;
  logic [2:0] cnt;
  logic [7:0] sr, byte_in;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  assign scl_s = scl_sr[SYNC_STAGES-1];
  assign sda_s = sda_sr[SYNC_STAGES-1];
  assign scl_rise = scl_s && !scl_d;
  assign scl_fall = !scl_s && scl_d;
  assign start = scl_s && scl_d && sda_d && !sda_s;
  assign stop = scl_s && scl_d && !sda_d && sda_s;
  assign last = scl_rise && cnt == 3'd7;
  assign byte_in = {sr[6:0], sda_s};
`ifdef I2C_GENERAL_CALL_EN
  assign addr_ok = !sda_s && (sr[6:0] == DEVICE_ADDR || sr[6:0] == 7'h00);
`else
  assign addr_ok = !sda_s && sr[6:0] == DEVICE_ADDR;
`endif
  // count MSB set means full because the depth is a power of two
  assign push = state == DATA && last && !count[AW];
  assign pop = bus.rx_valid && bus.rx_ready;
  assign bus.rx_valid = count != '0;
  assign bus.rx_data = bus.rx_valid ? mem[rp] : 8'h00;
  // synchronise pads (idle bus high) and keep one-clk-old copies for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sr <= '1;
      sda_sr <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_sr <= {scl_sr[SYNC_STAGES-2:0], bus.scl_i};
      sda_sr <= {sda_sr[SYNC_STAGES-2:0], bus.sda_i};
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end
  // protocol FSM; START/STOP override whatever the byte logic decided
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      ph <= 1'b0;
      ack <= 1'b0;
      bus.sda_oe <= 1'b0;
      bus.busy <= 1'b0;
      bus.addr_hit <= 1'b0;
      bus.overrun <= 1'b0;
      bus.stop_det <= 1'b0;
    end else begin
      bus.addr_hit <= 1'b0;
      bus.overrun <= 1'b0;
      bus.stop_det <= 1'b0;
      if (scl_rise) begin
        sr <= byte_in;
        cnt <= cnt + 3'd1;
      end
      case (state)
        ADDR: if (last) begin
          state <= addr_ok ? ADDR_ACK : IGNORE;
          ack <= 1'b1;
        end
        DATA: if (last) begin
          state <= DATA_ACK;
          ack <= !count[AW];
          bus.overrun <= count[AW];
        end
        ADDR_ACK, DATA_ACK: if (scl_fall) begin
          ph <= !ph;
          bus.sda_oe <= !ph && ack;
          bus.addr_hit <= !ph && state == ADDR_ACK;
          if (ph) begin
            state <= DATA;
            cnt <= '0;
          end
        end
        default: ;
      endcase
      if (start) begin
        state <= ADDR;
        cnt <= '0;
        ph <= 1'b0;
        bus.sda_oe <= 1'b0;
        bus.busy <= 1'b1;
      end
      if (stop) begin
        state <= IDLE;
        ph <= 1'b0;
        bus.sda_oe <= 1'b0;
        bus.busy <= 1'b0;
        bus.stop_det <= 1'b1;
      end
    end
  end
  // receive FIFO; full test uses the registered count so a same-clk pop never frees room
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= byte_in;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb_i2c_slave_rx: directed I2C host transactions against i2c_slave_rx with immediate-assertion checks
module tb_i2c_slave_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sda_h = 1'b1;
  logic a;
  int errors = 0, checks = 0;
  int n_hit = 0, n_ovr = 0, n_stop = 0, n_oe = 0;
  int s0;
  i2c_slave_rx_if bus();
  i2c_slave_rx dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.sda_i = sda_h & ~bus.sda_oe;
  // event counters for pulses and SDA drive
  always @(posedge clk) begin
    n_hit <= n_hit + int'(bus.addr_hit);
    n_ovr <= n_ovr + int'(bus.overrun);
    n_stop <= n_stop + int'(bus.stop_det);
    n_oe <= n_oe + int'(bus.sda_oe);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic w(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic bit_tx(input logic b);
    sda_h = b; w(5);
    bus.scl_i = 1'b1; w(10);
    bus.scl_i = 1'b0; w(5);
  endtask
  task automatic bits_tx(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) bit_tx(d[i]);
  endtask
  task automatic byte_tx(input logic [7:0] d, output logic ack);
    bits_tx(d);
    sda_h = 1'b1; w(5);
    bus.scl_i = 1'b1; w(5);
    ack = bus.sda_oe; w(5);
    bus.scl_i = 1'b0; w(5);
  endtask
  task automatic start_c();
    sda_h = 1'b1; w(5);
    bus.scl_i = 1'b1; w(5);
    sda_h = 1'b0; w(5);
    bus.scl_i = 1'b0; w(5);
  endtask
  task automatic stop_c();
    sda_h = 1'b0; w(5);
    bus.scl_i = 1'b1; w(5);
    sda_h = 1'b1; w(10);
  endtask
  task automatic pop_chk(input string tag, input logic [7:0] d);
    chk({tag, "_valid"}, bus.rx_valid, 1'b1);
    chk(tag, bus.rx_data, d);
    bus.rx_ready = 1'b1; w(1);
    bus.rx_ready = 1'b0;
  endtask
  initial begin
    bus.scl_i = 1'b1;
    bus.rx_ready = 1'b0;
    w(3);
    rst = 1'b0; w(1);
    chk("rst_sda_oe", bus.sda_oe, 1'b0);
    chk("rst_valid", bus.rx_valid, 1'b0);
    chk("rst_data", bus.rx_data, 8'h00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_pulses", {bus.addr_hit, bus.overrun, bus.stop_det}, 3'b000);
    // reset while the address ACK is being driven
    start_c();
    chk("a_busy", bus.busy, 1'b1);
    bits_tx(8'hEE);
    sda_h = 1'b1; w(5);
    chk("a_ack_driven", bus.sda_oe, 1'b1);
    rst = 1'b1; w(2);
    rst = 1'b0; w(1);
    chk("a_rst_sda_oe", bus.sda_oe, 1'b0);
    chk("a_rst_valid", bus.rx_valid, 1'b0);
    chk("a_rst_busy", bus.busy, 1'b0);
    start_c();
    byte_tx(8'hEE, a); chk("a_addr_ack", a, 1'b1);
    byte_tx(8'h41, a); chk("a_data_ack", a, 1'b1);
    w(2);
    pop_chk("a_pop41", 8'h41);
    chk("a_empty", bus.rx_valid, 1'b0);
    stop_c();
    // three-byte write with STOP
    s0 = n_stop;
    start_c();
    byte_tx(8'hEE, a); chk("b_addr_ack", a, 1'b1);
    byte_tx(8'h5A, a); chk("b_ack5a", a, 1'b1);
    byte_tx(8'hC3, a); chk("b_ackc3", a, 1'b1);
    stop_c();
    chk("b_stop_pulses", n_stop - s0, 1);
    chk("b_busy", bus.busy, 1'b0);
    pop_chk("b_pop5a", 8'h5A);
    pop_chk("b_popc3", 8'hC3);
    chk("b_empty", bus.rx_valid, 1'b0);
    // read request is ignored
    s0 = n_oe;
    start_c();
    byte_tx(8'hEF, a); chk("c_nack", a, 1'b0);
    byte_tx(8'h33, a); chk("c_data_nack", a, 1'b0);
    chk("c_oe_never", n_oe - s0, 0);
    chk("c_empty", bus.rx_valid, 1'b0);
    stop_c();
    // overflow: four accepted, fifth NACKed
    s0 = n_ovr;
    start_c();
    byte_tx(8'hEE, a); chk("d_addr_ack", a, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      byte_tx(8'(k), a);
      chk($sformatf("d_ack%0d", k), a, k != 5);
    end
    stop_c();
    chk("d_overrun", n_ovr - s0, 1);
    for (int k = 1; k <= 4; k++) pop_chk($sformatf("d_pop%0d", k), 8'(k));
    chk("d_empty", bus.rx_valid, 1'b0);
    // repeated START mid-byte discards the partial byte
    s0 = n_hit;
    start_c();
    byte_tx(8'hEE, a); chk("e_addr_ack1", a, 1'b1);
    bit_tx(1'b1); bit_tx(1'b0); bit_tx(1'b1); bit_tx(1'b0);
    start_c();
    byte_tx(8'hEE, a); chk("e_addr_ack2", a, 1'b1);
    byte_tx(8'h99, a); chk("e_ack99", a, 1'b1);
    stop_c();
    chk("e_hits", n_hit - s0, 2);
    pop_chk("e_pop99", 8'h99);
    chk("e_empty", bus.rx_valid, 1'b0);
    // general call address
    s0 = n_hit;
    start_c();
    byte_tx(8'h00, a);
`ifdef I2C_GENERAL_CALL_EN
    chk("f_gc_ack", a, 1'b1);
    byte_tx(8'h12, a); chk("f_ack12", a, 1'b1);
    stop_c();
    chk("f_hits", n_hit - s0, 1);
    pop_chk("f_pop12", 8'h12);
`else
    chk("f_gc_nack", a, 1'b0);
    byte_tx(8'h12, a); chk("f_nack12", a, 1'b0);
    stop_c();
    chk("f_hits", n_hit - s0, 0);
`endif
    chk("f_empty", bus.rx_valid, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
